// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port.
// Two requesters (A = ALU result, B = load result) share the port under
// round-robin priority. The write port is registered, and a per-register
// busy scoreboard tracks outstanding producers for RAW-hazard stalls.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_valid,
  input  logic [ADDR_W-1:0]   a_reg,
  input  logic [DATA_W-1:0]   a_data,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [ADDR_W-1:0]   b_reg,
  input  logic [DATA_W-1:0]   b_data,
  output logic                b_ready,
  input  logic                hold,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_reg,
  output logic                regWrite,
  output logic [ADDR_W-1:0]   writeReg,
  output logic [DATA_W-1:0]   writeData,
  output logic [NUM_REGS-1:0] busy
);

  // Priority pointer: names the requester that wins when both are valid.
  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_e;

  pri_e                pri_q, pri_d;
  logic                reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic                a_gnt, b_gnt, xfer;
  logic [ADDR_W-1:0]   sel_reg;
  logic [DATA_W-1:0]   sel_data;

  // Grant selection; a grant only goes to a valid requester, and none while
  // held or in reset, so ready doubles as the transfer indication.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n && !hold) begin
      if (a_valid && (!b_valid || pri_q == PRI_A)) begin
        a_gnt = 1'b1;
      end else if (b_valid) begin
        b_gnt = 1'b1;
      end
    end
  end

  assign a_ready  = a_gnt;
  assign b_ready  = b_gnt;
  assign xfer     = a_gnt | b_gnt;
  assign sel_reg  = a_gnt ? a_reg  : b_reg;
  assign sel_data = a_gnt ? a_data : b_data;

  // Next-state for pointer, write port and scoreboard; a reservation on the
  // same edge as a clearing transfer is the newer producer, so set wins.
  always_comb begin
    pri_d        = pri_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    busy_d       = busy_q;
    if (a_gnt) begin
      pri_d = PRI_B;
    end else if (b_gnt) begin
      pri_d = PRI_A;
    end
    if (xfer) begin
      reg_write_d  = (sel_reg != '0);
      write_reg_d  = sel_reg;
      write_data_d = sel_data;
      if (sel_reg != '0) begin
        busy_d[sel_reg] = 1'b0;
      end
    end
    if (rsv_valid && rsv_reg != '0) begin
      busy_d[rsv_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset drops any in-flight write pulse and clears busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q        <= PRI_A;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else begin
      pri_q        <= pri_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

  assign regWrite  = reg_write_q;
  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: handshakes, round-robin order,
// write-port latency, scoreboard set/clear, register 0, hold and async reset.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        b_ready;
  logic        hold;
  logic        rsv_valid;
  logic [4:0]  rsv_reg;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [31:0] busy;

  int checkCount;
  int failCount;

  regfile_wb_arbiter #(
    .DATA_W(32),
    .ADDR_W(5),
    .NUM_REGS(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a_valid(a_valid),
    .a_reg(a_reg),
    .a_data(a_data),
    .a_ready(a_ready),
    .b_valid(b_valid),
    .b_reg(b_reg),
    .b_data(b_data),
    .b_ready(b_ready),
    .hold(hold),
    .rsv_valid(rsv_valid),
    .rsv_reg(rsv_reg),
    .regWrite(regWrite),
    .writeReg(writeReg),
    .writeData(writeData),
    .busy(busy)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives every requester input in one call.
  task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                               input logic bv, input logic [4:0] br, input logic [31:0] bd,
                               input logic hl, input logic rv, input logic [4:0] rr);
    a_valid   = av;
    a_reg     = ar;
    a_data    = ad;
    b_valid   = bv;
    b_reg     = br;
    b_data    = bd;
    hold      = hl;
    rsv_valid = rv;
    rsv_reg   = rr;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Async reset pulse, released away from the clock edge.
  task automatic pulseReset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst_n      = 1'b0;
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd4, 32'h0, 1'b0, 1'b0, 5'd0);

    // Reset values, with requests pending to show ready is gated.
    checkOutput("rst_regWrite", 32'(regWrite), 32'h0);
    checkOutput("rst_writeReg", 32'(writeReg), 32'h0);
    checkOutput("rst_writeData", writeData, 32'h0);
    checkOutput("rst_busy", busy, 32'h0);
    checkOutput("rst_a_ready", 32'(a_ready), 32'h0);
    checkOutput("rst_b_ready", 32'(b_ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single A write: one-cycle latency, one-cycle pulse.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    checkOutput("t1_a_ready", 32'(a_ready), 32'h1);
    checkOutput("t1_b_ready", 32'(b_ready), 32'h0);
    stepClock();
    checkOutput("t1_regWrite", 32'(regWrite), 32'h1);
    checkOutput("t1_writeReg", 32'(writeReg), 32'd5);
    checkOutput("t1_writeData", writeData, 32'hDEADBEEF);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    stepClock();
    checkOutput("t1_regWrite_end", 32'(regWrite), 32'h0);
    checkOutput("t1_writeReg_hold", 32'(writeReg), 32'd5);

    // Both valid after reset: A,B,A,B with a write every cycle.
    pulseReset();
    applyStimulus(1'b1, 5'd3, 32'h11111111, 1'b1, 5'd4, 32'h22222222, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr%0d_a_ready", i), 32'(a_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
      checkOutput($sformatf("rr%0d_b_ready", i), 32'(b_ready), (i % 2 == 0) ? 32'h0 : 32'h1);
      stepClock();
      checkOutput($sformatf("rr%0d_regWrite", i), 32'(regWrite), 32'h1);
      checkOutput($sformatf("rr%0d_writeReg", i), 32'(writeReg), (i % 2 == 0) ? 32'd3 : 32'd4);
      checkOutput($sformatf("rr%0d_writeData", i), writeData,
                  (i % 2 == 0) ? 32'h11111111 : 32'h22222222);
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);

    // Reserve r7, B writes r7 four cycles later.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd7);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    checkOutput("sb7_set", busy, 32'h0000_0080);
    stepClock();
    stepClock();
    stepClock();
    checkOutput("sb7_still_busy", busy, 32'h0000_0080);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77777777, 1'b0, 1'b0, 5'd0);
    checkOutput("sb7_b_ready", 32'(b_ready), 32'h1);
    stepClock();
    checkOutput("sb7_cleared", busy, 32'h0);
    checkOutput("sb7_regWrite", 32'(regWrite), 32'h1);
    checkOutput("sb7_writeReg", 32'(writeReg), 32'd7);
    checkOutput("sb7_writeData", writeData, 32'h77777777);

    // Reserve r9 on the same edge as A's transfer to r9: set wins.
    applyStimulus(1'b1, 5'd9, 32'h99999999, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd9);
    checkOutput("sb9_a_ready", 32'(a_ready), 32'h1);
    stepClock();
    checkOutput("sb9_busy", busy, 32'h0000_0200);
    checkOutput("sb9_writeReg", 32'(writeReg), 32'd9);

    // Write to r0 plus reserve of r0: handshake only, no pulse, no busy change.
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd0);
    checkOutput("r0_a_ready", 32'(a_ready), 32'h1);
    stepClock();
    checkOutput("r0_regWrite", 32'(regWrite), 32'h0);
    checkOutput("r0_busy", busy, 32'h0000_0200);

    // Hold with both valid; pointer (now B after the r0 transfer) must survive.
    applyStimulus(1'b1, 5'd3, 32'h11111111, 1'b1, 5'd4, 32'h22222222, 1'b1, 1'b0, 5'd0);
    checkOutput("hold_a_ready", 32'(a_ready), 32'h0);
    checkOutput("hold_b_ready", 32'(b_ready), 32'h0);
    stepClock();
    checkOutput("hold_regWrite", 32'(regWrite), 32'h0);
    applyStimulus(1'b1, 5'd3, 32'h11111111, 1'b1, 5'd4, 32'h22222222, 1'b0, 1'b0, 5'd0);
    checkOutput("unhold_a_ready", 32'(a_ready), 32'h0);
    checkOutput("unhold_b_ready", 32'(b_ready), 32'h1);
    stepClock();
    checkOutput("unhold_regWrite", 32'(regWrite), 32'h1);
    checkOutput("unhold_writeReg", 32'(writeReg), 32'd4);

    // Async reset mid-pulse: pulse and busy drop at once, pointer back to A.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_regWrite", 32'(regWrite), 32'h0);
    checkOutput("midrst_busy", busy, 32'h0);
    checkOutput("midrst_a_ready", 32'(a_ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("postrst_a_ready", 32'(a_ready), 32'h1);
    checkOutput("postrst_b_ready", 32'(b_ready), 32'h0);
    stepClock();
    checkOutput("postrst_writeReg", 32'(writeReg), 32'd3);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
